pipe_reg: RTL and testbench
===========================

# pipe_reg

Parametrised, elastic register pipeline: DEPTH stages of WIDTH-bit registers with per-stage valid bits, a valid/ready handshake on both ends, bubble collapsing, synchronous flush and an occupancy count. It generalises the single asynchronously-reset flop into the standard retiming and delay element for datapaths. It sits between any two valid/ready blocks where extra register stages are needed without losing throughput or data under back-pressure.

## Interface
- WIDTH, 8, data width in bits (≥1)
- DEPTH, 4, number of register stages (≥1)
- RST_VAL, 0, WIDTH-bit value loaded into every data register on reset and flush
- clk  input  1  clock; all state changes on rising edge
- rst  input  1  reset, asynchronous, active-high
- flush  input  1  synchronous clear of all valid bits
- in_valid  input  1  upstream offers in_data
- in_data  input  WIDTH  upstream data
- in_ready  output  1  pipeline accepts in_data this cycle
- out_valid  output  1  stage DEPTH-1 holds valid data
- out_data  output  WIDTH  stage DEPTH-1 data register
- out_ready  input  1  downstream accepts out_data this cycle
- count  output  $clog2(DEPTH+1)  number of valid stages, 0..DEPTH

## Operation
- State: data[i] (WIDTH) and v[i] (1) for i = 0..DEPTH-1; stage 0 is the input side, stage DEPTH-1 drives the outputs.
- Reset (rst=1, asynchronous): all v[i]=0, all data[i]=RST_VAL, count=0. Outputs during and after reset: out_valid=0, out_data=RST_VAL, in_ready=1 (because flush=0 and the pipeline is empty).
- Advance condition, evaluated combinationally from the output side:
  - adv[DEPTH-1] = !v[DEPTH-1] | out_ready.
  - adv[i] = !v[i] | adv[i+1].
  - A stage advances when it is empty or its successor advances. This collapses bubbles: an empty stage always accepts.
- in_ready = adv[0] & !flush.
- On a clock edge with flush=0:
  - For i ≥ 1 with adv[i]=1: data[i] ← data[i-1] and v[i] ← v[i-1].
  - Stage 0 with adv[0]=1: v[0] ← in_valid. data[0] ← in_data when in_valid=1; otherwise data is held.
  - Stages with adv[i]=0 hold data and valid.
  - Data registers only load on a valid move, so invalid stages keep stale data.
- Flush (flush=1):
  - Next edge: all v[i] ← 0 and all data[i] ← RST_VAL.
  - in_ready=0 and out_valid=0 in the flush cycle, so no transfer occurs on either side.
  - in_valid is ignored during flush.
- out_valid = v[DEPTH-1] & !flush. out_data = data[DEPTH-1].
- count is the registered population of v[]:
  - +1 on accept only, −1 on emit only, unchanged on both or neither.
  - Set to 0 on flush and reset.
  - Always equals the number of set v[i].
- Handshake rules:
  - A transfer occurs when valid & ready are both high at the edge.
  - out_valid and out_data stay stable while out_valid=1 and out_ready=0.
  - in_ready may depend combinationally on out_ready. No combinational path exists from in_valid to in_ready.

## Timing
- Latency: a word accepted at edge N appears on out_data/out_valid after edge N+DEPTH-1 when it passes through an empty, unstalled pipeline. It is emitted no earlier than edge N+DEPTH.
- Throughput: 1 word per cycle while out_ready=1 continuously.
- Full: count=DEPTH and out_ready=0 gives in_ready=0. If out_ready=1 while full, in_ready=1 in the same cycle, so a simultaneous accept and emit leaves count=DEPTH.
- Empty: out_valid=0 and in_ready=1 (unless flush).
- Stall: out_ready=0 fills the pipe. Stages fill from DEPTH-1 backward, one per accepted word, with no data loss.
- DEPTH=1: degenerates to a single-register stage with in_ready = !v[0] | out_ready.
- Reset asserted mid-stream drops all in-flight data immediately. No output transfer is counted in that cycle.

## Test plan
- Reset: assert rst for 3 cycles with in_valid=1 and in_data=8'hAA. Required: out_valid=0, out_data=RST_VAL, count=0, in_ready=1 after release.
- Streaming (DEPTH=4, out_ready=1): send 8'h01..8'h10 back-to-back. Required: out_valid first high 4 cycles after the first accept, values in order, 1 per cycle, count steady at 4 during the stream.
- Back-pressure: hold out_ready=0 and send 6 words. Required: 4 accepted (count=4), then in_ready=0. Release out_ready. Required: words 1..4 emerge in order, and words 5..6 are then accepted and delivered.
- Bubble collapse: send 8'h11, one idle cycle, then 8'h22 with out_ready=0. Required: both held, count=2. Release out_ready. Required: 8'h11 then 8'h22 on consecutive cycles.
- Flush: with count=3, pulse flush while in_valid=1. Required: in_ready=0 and out_valid=0 that cycle, count=0 next cycle, the input word is never output, and out_data=RST_VAL.
- Simultaneous full accept and emit: count=4 with out_ready=1 and in_valid=1. Required: in_ready=1, count stays 4, and the new word exits 4 cycles later.

Source files
------------

// File: rtl/pipe_reg.sv
// pipe_reg: elastic register pipeline of DEPTH stages, WIDTH bits each.
// Valid/ready on both ends, bubble collapsing, synchronous flush and a
// registered occupancy count. Stage 0 faces the input, stage DEPTH-1 drives
// the outputs.
module pipe_reg #(
    parameter int unsigned          WIDTH   = 8,
    parameter int unsigned          DEPTH   = 4,
    parameter logic [WIDTH-1:0]     RST_VAL = '0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        in_valid,
    input  logic [WIDTH-1:0]            in_data,
    output logic                        in_ready,
    output logic                        out_valid,
    output logic [WIDTH-1:0]            out_data,
    input  logic                        out_ready,
    output logic [$clog2(DEPTH+1)-1:0]  count
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] stageData_q [DEPTH];
    logic [WIDTH-1:0] stageData_d [DEPTH];
    logic [DEPTH-1:0] stageValid_q;
    logic [DEPTH-1:0] stageValid_d;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;

    logic [DEPTH-1:0] advance;
    logic             acceptFire;
    logic             emitFire;

    // A stage may move when it is empty or anything downstream of it can
    // move; a running OR from the output side avoids a self-referencing chain.
    always_comb begin
        logic advAcc;
        advAcc = !stageValid_q[DEPTH-1] | out_ready;
        advance = '0;
        advance[DEPTH-1] = advAcc;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            advAcc = advAcc | !stageValid_q[i];
            advance[i] = advAcc;
        end
    end

    assign in_ready   = advance[0] & !flush;
    assign out_valid  = stageValid_q[DEPTH-1] & !flush;
    assign out_data   = stageData_q[DEPTH-1];
    assign count      = count_q;
    assign acceptFire = in_valid & in_ready;
    assign emitFire   = out_valid & out_ready;

    // Next stage contents: shift on advance, load data only on a valid move
    // so empty stages keep stale data; flush wipes everything.
    always_comb begin
        stageValid_d = stageValid_q;
        stageData_d  = stageData_q;
        if (flush) begin
            stageValid_d = '0;
            for (int i = 0; i < DEPTH; i++) begin
                stageData_d[i] = RST_VAL;
            end
        end else begin
            for (int i = DEPTH - 1; i >= 1; i--) begin
                if (advance[i]) begin
                    stageValid_d[i] = stageValid_q[i-1];
                    if (stageValid_q[i-1]) begin
                        stageData_d[i] = stageData_q[i-1];
                    end
                end
            end
            if (advance[0]) begin
                stageValid_d[0] = in_valid;
                if (in_valid) begin
                    stageData_d[0] = in_data;
                end
            end
        end
    end

    // Occupancy tracks accepts and emits; both or neither leaves it unchanged.
    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else if (acceptFire && !emitFire) begin
            count_d = count_q + CW'(1);
        end else if (emitFire && !acceptFire) begin
            count_d = count_q - CW'(1);
        end
    end

    // State registers with asynchronous reset back to an empty pipeline.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stageValid_q <= '0;
            count_q      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                stageData_q[i] <= RST_VAL;
            end
        end else begin
            stageValid_q <= stageValid_d;
            count_q      <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                stageData_q[i] <= stageData_d[i];
            end
        end
    end

endmodule

// File: tb/tb_pipe_reg.sv
// tb_pipe_reg: directed and random stimulus for pipe_reg, compared each
// cycle against a queue-of-words reference model.
module tb_pipe_reg;

    localparam int          WIDTH   = 8;
    localparam int          DEPTH   = 4;
    localparam logic [7:0]  RST_VAL = 8'h5A;
    localparam int          CW      = $clog2(DEPTH + 1);

    logic            clk = 1'b0;
    logic            rst;
    logic            flush;
    logic            in_valid;
    logic [7:0]      in_data;
    logic            in_ready;
    logic            out_valid;
    logic [7:0]      out_data;
    logic            out_ready;
    logic [CW-1:0]   count;

    int assertCount = 0;
    int failCount   = 0;

    // Reference model: words in flight, oldest first, each with its stage index.
    typedef struct {
        int         pos;
        logic [7:0] data;
    } word_t;
    word_t      pipe[$];
    logic [7:0] lastOut;

    pipe_reg #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RST_VAL(RST_VAL)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .count     (count)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    function automatic logic modelInReady(input logic fl, input logic outR);
        return !fl && ((pipe.size() < DEPTH) || outR);
    endfunction

    function automatic logic modelOutValid(input logic fl);
        return !fl && (pipe.size() > 0) && (pipe[0].pos == DEPTH - 1);
    endfunction

    function automatic void modelClear();
        pipe.delete();
        lastOut = RST_VAL;
    endfunction

    // One clock edge of the model: emit the head, slide every word forward
    // as far as the word ahead of it allows, then append the accepted word.
    function automatic void modelStep(input logic inV, input logic [7:0] inD,
                                      input logic outR, input logic fl);
        logic emit;
        logic accept;
        int   limit;
        int   np;
        if (fl) begin
            modelClear();
            return;
        end
        emit   = modelOutValid(fl) && outR;
        accept = inV && modelInReady(fl, outR);
        if (emit) void'(pipe.pop_front());
        limit = DEPTH - 1;
        for (int i = 0; i < pipe.size(); i++) begin
            np = (pipe[i].pos + 1 > limit) ? limit : pipe[i].pos + 1;
            if (np == DEPTH - 1 && pipe[i].pos != DEPTH - 1) lastOut = pipe[i].data;
            pipe[i].pos = np;
            limit = np - 1;
        end
        if (accept) begin
            word_t w;
            w.pos  = 0;
            w.data = inD;
            pipe.push_back(w);
            if (DEPTH == 1) lastOut = inD;
        end
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Compare every DUT output against the model for the current inputs.
    task automatic checkOutput(input logic fl, input logic outR);
        check("in_ready",  32'(in_ready),  32'(modelInReady(fl, outR)));
        check("out_valid", 32'(out_valid), 32'(modelOutValid(fl)));
        check("out_data",  32'(out_data),  32'(lastOut));
        check("count",     32'(count),     32'(pipe.size()));
    endtask

    // Drive one cycle from a negedge, check, step the model at the posedge.
    task automatic applyStimulus(input logic v, input logic [7:0] d, input logic r,
                                 input logic f, output logic acc);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
        #1;
        checkOutput(f, r);
        acc = v && modelInReady(f, r);
        @(posedge clk);
        modelStep(v, d, r, f);
        @(negedge clk);
    endtask

    initial begin
        logic acc;
        int   k;
        int   guard;

        modelClear();

        // Reset held three cycles while upstream offers 8'hAA.
        rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 8'hAA; out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("reset out_valid", 32'(out_valid), 32'(0));
            check("reset out_data",  32'(out_data),  32'(RST_VAL));
            check("reset count",     32'(count),     32'(0));
            check("reset in_ready",  32'(in_ready),  32'(1));
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b0;
        in_valid = 1'b0;
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, acc);

        // Streaming 8'h01..8'h10 with downstream always ready, then drain.
        for (int i = 1; i <= 16; i++) applyStimulus(1'b1, 8'(i), 1'b1, 1'b0, acc);
        for (int i = 0; i < DEPTH + 1; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, acc);

        // Back-pressure: six words offered against a stalled output.
        k = 1;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(k <= 6, 8'(8'h30 + k), 1'b0, 1'b0, acc);
            if (acc) k++;
        end
        check("backpressure full count", 32'(count), 32'(DEPTH));
        guard = 0;
        while ((k <= 6 || pipe.size() > 0) && guard < 30) begin
            applyStimulus(k <= 6, 8'(8'h30 + k), 1'b1, 1'b0, acc);
            if (acc) k++;
            guard++;
        end
        check("backpressure drained", 32'(pipe.size() == 0 && k == 7), 32'(1));

        // Bubble collapse: 11, idle, 22 against a stalled output, then release.
        applyStimulus(1'b1, 8'h11, 1'b0, 1'b0, acc);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, acc);
        applyStimulus(1'b1, 8'h22, 1'b0, 1'b0, acc);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, acc);
        check("bubble count", 32'(count), 32'(2));
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, acc);

        // Flush with three words resident and a word offered.
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, acc);
        check("preflush count", 32'(count), 32'(3));
        applyStimulus(1'b1, 8'hEE, 1'b1, 1'b1, acc);
        check("postflush count", 32'(count), 32'(0));
        for (int i = 0; i < DEPTH + 1; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, acc);

        // Full pipe with simultaneous accept and emit, then drain.
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 8'(8'h50 + i), 1'b0, 1'b0, acc);
        applyStimulus(1'b1, 8'hC3, 1'b1, 1'b0, acc);
        check("full swap count", 32'(count), 32'(DEPTH));
        for (int i = 0; i < DEPTH + 1; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, acc);

        // Reset asserted between edges while words are in flight.
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'(8'h60 + i), 1'b0, 1'b0, acc);
        #2 rst = 1'b1;
        #1;
        modelClear();
        check("midreset out_valid", 32'(out_valid), 32'(0));
        check("midreset count",     32'(count),     32'(0));
        check("midreset out_data",  32'(out_data),  32'(RST_VAL));
        @(negedge clk);
        rst = 1'b0;

        // Random traffic with occasional flushes.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 3) != 0), 8'($urandom),
                          1'($urandom_range(0, 2) != 0),
                          1'($urandom_range(0, 24) == 0), acc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
